// File: rtl/sa_dma_pkg.sv
// Shared types and helpers for the systolic-array DMA schedulers.
package sa_dma_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned RR_MAX = 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    RUN,
    RESP,
    GAP
  } wr_sched_state_t;

  // One-hot round-robin winner: first set bit searching upward from ptr+1, wrapping at n.
  function automatic logic [RR_MAX-1:0] next_rr(input logic [RR_MAX-1:0] req,
                                                input logic [2:0]        ptr,
                                                input logic [3:0]        n);
    logic [RR_MAX-1:0] oh;
    logic              found;
    int unsigned       idx;
    oh    = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned i = 1; i <= RR_MAX; i++) begin
      if (i <= 32'(n)) begin
        idx = (32'(ptr) + i) % 32'(n);
        if (!found && req[idx[2:0]]) begin
          oh[idx[2:0]] = 1'b1;
          found        = 1'b1;
        end
      end
    end
    return oh;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker; shared by the write and future read schedulers.
module dma_rr_pick
  import sa_dma_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_onehot_c,
  output logic [IDX_W-1:0] o_index_c,
  output logic             o_any_c
);

  logic [RR_MAX-1:0] w_oh_full;

  assign w_oh_full  = next_rr(RR_MAX'(i_req), 3'(i_ptr), 4'(N_REQ));
  assign o_onehot_c = N_REQ'(w_oh_full);
  assign o_any_c    = |i_req;

  // Binary index of the one-hot winner.
  always_comb begin
    o_index_c = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (o_onehot_c[k]) o_index_c = IDX_W'(k);
    end
  end

endmodule

// File: rtl/dma_wr_sched.sv
// Round-robin scheduler sharing one AXI write DMA among N_REQ producers.
// Optional watchdog: define DMA_WR_SCHED_TIMEOUT_EN to abort a job with an
// error after TIMEOUT_CYCLES in RUN without a DMA done.
module dma_wr_sched
  import sa_dma_pkg::*;
#(
  parameter  int unsigned N_REQ          = 4,
  parameter  int unsigned DATA_W         = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned IDX_W          = $clog2(N_REQ)
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ*ADDR_W-1:0]   i_base_addr,
  input  logic [N_REQ*LEN_W-1:0]    i_byte_len,
  output logic [N_REQ-1:0]          o_grant,
  output logic [N_REQ-1:0]          o_done,
  output logic [N_REQ-1:0]          o_error,
  input  logic [N_REQ*DATA_W-1:0]   i_data,
  input  logic [N_REQ-1:0]          i_valid,
  output logic [N_REQ-1:0]          o_ready,
  output logic                      o_busy,
  output logic                      o_dma_start,
  output logic [ADDR_W-1:0]         o_dma_base_addr,
  output logic [LEN_W-1:0]          o_dma_byte_len,
  input  logic                      i_dma_busy,
  input  logic                      i_dma_done,
  input  logic                      i_dma_error,
  output logic [DATA_W-1:0]         o_dma_data,
  output logic                      o_dma_valid,
  input  logic                      i_dma_ready
);

  wr_sched_state_t   r_state;
  logic [IDX_W-1:0]  r_ptr;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  r_done;
  logic [N_REQ-1:0]  r_error;
  logic              r_busy;
  logic              r_dma_start;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
`ifdef DMA_WR_SCHED_TIMEOUT_EN
  logic [31:0]       r_tcnt;
`endif

  logic [N_REQ-1:0]  w_pick_oh;
  logic [IDX_W-1:0]  w_pick_idx;
  logic              w_pick_any;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LEN_W-1:0]  w_sel_len;
  logic [N_REQ-1:0]  w_route;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic [N_REQ-1:0]  w_ready;
  logic              w_unused;

  // DMA busy is status only and the watchdog limit is unused without the feature.
  assign w_unused = i_dma_busy | (TIMEOUT_CYCLES == 32'd0);

  dma_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req      (i_req),
    .i_ptr      (r_ptr),
    .o_onehot_c (w_pick_oh),
    .o_index_c  (w_pick_idx),
    .o_any_c    (w_pick_any)
  );

  // Address/length of the round-robin winner.
  always_comb begin
    w_sel_addr = '0;
    w_sel_len  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_pick_oh[k]) begin
        w_sel_addr = w_sel_addr | i_base_addr[k*ADDR_W +: ADDR_W];
        w_sel_len  = w_sel_len  | i_byte_len[k*LEN_W +: LEN_W];
      end
    end
  end

  // Stream steering from the owner to the DMA, open only while the job runs.
  assign w_route = (r_state == RUN) ? r_grant : '0;

  always_comb begin
    w_data  = '0;
    w_valid = 1'b0;
    w_ready = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_route[k]) begin
        w_data     = w_data | i_data[k*DATA_W +: DATA_W];
        w_valid    = w_valid | i_valid[k];
        w_ready[k] = i_dma_ready;
      end
    end
  end

  // Job FSM: arbitrate, launch, wait for completion, respond, then a guard cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_done      <= '0;
      r_error     <= '0;
      r_busy      <= 1'b0;
      r_dma_start <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
`ifdef DMA_WR_SCHED_TIMEOUT_EN
      r_tcnt      <= '0;
`endif
    end else begin
      r_done      <= '0;
      r_error     <= '0;
      r_dma_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pick_any) begin
            r_grant <= w_pick_oh;
            r_busy  <= 1'b1;
            r_addr  <= w_sel_addr;
            r_len   <= w_sel_len;
            r_ptr   <= w_pick_idx;
            if (w_sel_len == '0) begin
              r_done  <= w_pick_oh;
              r_state <= RESP;
            end else begin
              r_state <= LAUNCH;
            end
          end
        end
        LAUNCH: begin
          r_dma_start <= 1'b1;
`ifdef DMA_WR_SCHED_TIMEOUT_EN
          r_tcnt      <= '0;
`endif
          r_state     <= RUN;
        end
        RUN: begin
          if (i_dma_done) begin
            r_done  <= r_grant;
            r_error <= i_dma_error ? r_grant : '0;
            r_state <= RESP;
          end
`ifdef DMA_WR_SCHED_TIMEOUT_EN
          else if (r_tcnt == 32'(TIMEOUT_CYCLES)) begin
            r_done  <= r_grant;
            r_error <= r_grant;
            r_state <= RESP;
          end else begin
            r_tcnt <= r_tcnt + 32'd1;
          end
`endif
        end
        RESP: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= GAP;
        end
        GAP:     r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_grant         = r_grant;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_busy          = r_busy;
  assign o_dma_start     = r_dma_start;
  assign o_dma_base_addr = r_addr;
  assign o_dma_byte_len  = r_len;
  assign o_dma_data      = w_data;
  assign o_dma_valid     = w_valid;
  assign o_ready         = w_ready;

endmodule

// File: tb/tb_dma_wr_sched.sv
// Scoreboard bench for dma_wr_sched with a small behavioural DMA model.
module tb_dma_wr_sched;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;

  logic            ACLK   = 1'b0;
  logic            ARESET = 1'b1;
  logic [N-1:0]    i_req;
  logic [N*32-1:0] i_base_addr;
  logic [N*32-1:0] i_byte_len;
  logic [N-1:0]    o_grant, o_done, o_error, o_ready;
  logic [N*DW-1:0] i_data;
  logic [N-1:0]    i_valid;
  logic            o_busy, o_dma_start, o_dma_valid;
  logic [31:0]     o_dma_base_addr, o_dma_byte_len;
  logic [DW-1:0]   o_dma_data;
  logic            i_dma_busy, i_dma_done, i_dma_error, i_dma_ready;

  dma_wr_sched #(.N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(20)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .i_req(i_req), .i_base_addr(i_base_addr),
    .i_byte_len(i_byte_len), .o_grant(o_grant), .o_done(o_done), .o_error(o_error),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .o_busy(o_busy),
    .o_dma_start(o_dma_start), .o_dma_base_addr(o_dma_base_addr),
    .o_dma_byte_len(o_dma_byte_len), .i_dma_busy(i_dma_busy), .i_dma_done(i_dma_done),
    .i_dma_error(i_dma_error), .o_dma_data(o_dma_data), .o_dma_valid(o_dma_valid),
    .i_dma_ready(i_dma_ready)
  );

  always #5 ACLK = ~ACLK;

  int n_checks  = 0;
  int n_fail    = 0;
  int start_cnt = 0;
  logic [N-1:0] exp_grant_q[$];
  logic [N-1:0] exp_done_q[$];
  logic [N-1:0] exp_err_q[$];
  logic [N-1:0] prev_grant = '0;

  int   dma_lat  = 4;
  logic dma_err  = 1'b0;
  logic dma_hang = 1'b0;
  int   dma_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares grants and completions against the expectation queues.
  always @(negedge ACLK) begin
    if (!ARESET) begin
      if (o_dma_start) start_cnt++;
      if (o_grant != '0 && prev_grant == '0) begin
        if (exp_grant_q.size() == 0) check("grant_unexpected", 64'(o_grant), 0);
        else check("grant_order", 64'(o_grant), 64'(exp_grant_q.pop_front()));
      end
      if (o_done != '0) begin
        if (exp_done_q.size() == 0) check("done_unexpected", 64'(o_done), 0);
        else begin
          check("done_owner", 64'(o_done), 64'(exp_done_q.pop_front()));
          check("error_owner", 64'(o_error), 64'(exp_err_q.pop_front()));
        end
      end
      if (o_error != '0 && o_done == '0) check("error_without_done", 64'(o_error), 0);
      if (o_ready != '0) check("ready_isolation", 64'(o_ready & ~o_grant), 0);
    end
    prev_grant = o_grant;
  end

  // DMA model: raises done (with configured error) dma_lat cycles after start.
  initial begin : dma_model
    i_dma_done  = 1'b0;
    i_dma_error = 1'b0;
    forever begin
      @(negedge ACLK);
      i_dma_done  = 1'b0;
      i_dma_error = 1'b0;
      if (ARESET) dma_cnt = 0;
      else if (o_dma_start && !dma_hang) dma_cnt = dma_lat;
      else if (dma_cnt > 0) begin
        dma_cnt--;
        if (dma_cnt == 0) begin
          i_dma_done  = 1'b1;
          i_dma_error = dma_err;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ACLK);
  endtask

  task automatic set_job(input int k, input logic [31:0] addr, input logic [31:0] len);
    i_base_addr[k*32 +: 32] = addr;
    i_byte_len[k*32 +: 32]  = len;
  endtask

  task automatic expect_job(input logic [N-1:0] owner, input logic [N-1:0] err);
    exp_grant_q.push_back(owner);
    exp_done_q.push_back(owner);
    exp_err_q.push_back(err);
  endtask

  task automatic wait_start(input int budget);
    int cyc;
    cyc = 0;
    while (!o_dma_start && cyc < budget) begin
      @(negedge ACLK);
      cyc++;
    end
    if (!o_dma_start) check("start_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n, input int budget, output int cyc);
    int cnt;
    cnt = 0;
    cyc = 0;
    while (cnt < n && cyc < budget) begin
      @(negedge ACLK);
      cyc++;
      if (o_done != '0) cnt++;
    end
    if (cnt < n) check("done_timeout", 64'(cnt), 64'(n));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_grant"}, 64'(o_grant), 0);
    check({tag, "_done"},  64'(o_done), 0);
    check({tag, "_error"}, 64'(o_error), 0);
    check({tag, "_busy"},  64'(o_busy), 0);
    check({tag, "_start"}, 64'(o_dma_start), 0);
    check({tag, "_valid"}, 64'(o_dma_valid), 0);
    check({tag, "_ready"}, 64'(o_ready), 0);
    check({tag, "_addr"},  64'(o_dma_base_addr), 0);
    check({tag, "_len"},   64'(o_dma_byte_len), 0);
    check({tag, "_data"},  64'(o_dma_data), 0);
  endtask

  int cyc;
  int s0;

  initial begin : stim
    i_req       = '0;
    i_base_addr = '0;
    i_byte_len  = '0;
    i_data      = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
    i_valid     = 4'b1111;
    i_dma_ready = 1'b0;
    i_dma_busy  = 1'b0;

    // Reset state
    ARESET = 1'b1;
    tick(2);
    check_all_zero("reset");
    ARESET = 1'b0;
    tick(1);

    // Single job with exact latency checks
    set_job(0, 32'h0000_1000, 32'd64);
    dma_lat = 4; dma_err = 1'b0; i_dma_ready = 1'b1;
    expect_job(4'b0001, 4'b0000);
    s0 = start_cnt;
    i_req = 4'b0001;
    tick(1);
    check("single_grant", 64'(o_grant), 64'h1);
    check("single_busy", 64'(o_busy), 1);
    check("single_addr", 64'(o_dma_base_addr), 64'h1000);
    check("single_len", 64'(o_dma_byte_len), 64);
    check("single_no_early_start", 64'(o_dma_start), 0);
    tick(1);
    check("single_start", 64'(o_dma_start), 1);
    wait_done(1, 50, cyc);
    i_req = '0;
    check("single_done_latency", 64'(cyc), 5);
    tick(1);
    check("single_busy_after", 64'(o_busy), 0);
    check("single_grant_after", 64'(o_grant), 0);
    check("single_done_pulse", 64'(o_done), 0);
    tick(2);
    check("single_start_count", 64'(start_cnt - s0), 1);

    // Error routed to owner 2
    set_job(2, 32'h0000_2000, 32'd128);
    dma_lat = 2; dma_err = 1'b1;
    expect_job(4'b0100, 4'b0100);
    i_req = 4'b0100;
    wait_done(1, 50, cyc);
    i_req = '0;
    dma_err = 1'b0;
    tick(3);

    // Fairness with all requests held, starting from pointer 0
    ARESET = 1'b1;
    tick(2);
    ARESET = 1'b0;
    set_job(1, 32'h0000_1100, 32'd16);
    set_job(2, 32'h0000_1200, 32'd16);
    set_job(3, 32'h0000_1300, 32'd16);
    expect_job(4'b0010, 4'b0000);
    expect_job(4'b0100, 4'b0000);
    expect_job(4'b1000, 4'b0000);
    expect_job(4'b0001, 4'b0000);
    expect_job(4'b0010, 4'b0000);
    dma_lat = 3;
    s0 = start_cnt;
    i_req = 4'b1111;
    wait_done(5, 200, cyc);
    i_req = '0;
    tick(4);
    check("fair_start_count", 64'(start_cnt - s0), 5);
    check("fair_idle_busy", 64'(o_busy), 0);

    // Zero-length job: no launch, no error
    set_job(2, 32'h0000_3000, 32'd0);
    expect_job(4'b0100, 4'b0000);
    s0 = start_cnt;
    i_req = 4'b0100;
    tick(1);
    check("zero_grant", 64'(o_grant), 64'h4);
    check("zero_done", 64'(o_done), 64'h4);
    check("zero_error", 64'(o_error), 0);
    i_req = '0;
    tick(1);
    check("zero_busy_after", 64'(o_busy), 0);
    tick(3);
    check("zero_no_start", 64'(start_cnt - s0), 0);

    // Mux isolation with owner 1
    set_job(1, 32'h0000_4000, 32'd256);
    dma_lat = 6;
    expect_job(4'b0010, 4'b0000);
    i_valid = 4'b1111; i_dma_ready = 1'b1;
    i_req = 4'b0010;
    wait_start(10);
    check("mux_data", 64'(o_dma_data), 64'hA0A0_0001);
    check("mux_valid", 64'(o_dma_valid), 1);
    check("mux_ready", 64'(o_ready), 64'h2);
    tick(1);
    i_valid = 4'b1101;
    #1;
    check("mux_valid_owner_low", 64'(o_dma_valid), 0);
    check("mux_ready_hold", 64'(o_ready), 64'h2);
    i_valid = 4'b1111;
    i_dma_ready = 1'b0;
    #1;
    check("mux_ready_follows", 64'(o_ready), 0);
    i_dma_ready = 1'b1;
    wait_done(1, 20, cyc);
    i_req = '0;
    tick(3);

    // Reset three cycles after start abandons the job
    dma_hang = 1'b1;
    exp_grant_q.push_back(4'b0001);
    i_req = 4'b0001;
    wait_start(10);
    tick(3);
    ARESET = 1'b1;
    i_req = '0;
    tick(1);
    check_all_zero("midreset");
    ARESET = 1'b0;
    tick(5);
    dma_hang = 1'b0;
    dma_lat = 3;
    expect_job(4'b0001, 4'b0000);
    i_req = 4'b0001;
    wait_done(1, 30, cyc);
    i_req = '0;
    tick(3);

`ifdef DMA_WR_SCHED_TIMEOUT_EN
    // Watchdog: DMA never finishes
    dma_hang = 1'b1;
    set_job(2, 32'h0000_5000, 32'd32);
    expect_job(4'b0100, 4'b0100);
    i_req = 4'b0100;
    wait_start(10);
    wait_done(1, 40, cyc);
    check("timeout_latency", 64'(cyc), 21);
    i_req = '0;
    dma_hang = 1'b0;
    tick(3);
`endif

    check("grant_q_drained", 64'(exp_grant_q.size()), 0);
    check("done_q_drained", 64'(exp_done_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_wr_sched.md
Name: dma_wr_sched

Overview:
- Shares the single AXI write DMA engine (dma_write) among N result producers, e.g. systolic-array output tiles or a bias/activation writeback path.
- Arbitrates pending write jobs round-robin and launches exactly one DMA job at a time.
- Steers the granted requester's data stream to the engine and routes done/error back to that requester.
- Sits between the array's writeback units and dma_write inside sa_engine.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, data stream width; equals the DMA's C_M_AXI_DATA_WIDTH.
- TIMEOUT_CYCLES, 65535, watchdog limit in cycles; used only with DMA_WR_SCHED_TIMEOUT_EN.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset, synchronous, active-high.
- i_req  in  N_REQ  per-requester job request; level, held until that requester's o_done.
- i_base_addr  in  N_REQ*32  per-requester destination byte address, packed with requester 0 in the LSBs.
- i_byte_len  in  N_REQ*32  per-requester job length in bytes, packed.
- o_grant  out  N_REQ  one-hot; marks the owner of the current job.
- o_done  out  N_REQ  one-cycle completion pulse to the owner.
- o_error  out  N_REQ  one-cycle error pulse; coincides with o_done.
- i_data  in  N_REQ*DATA_W  per-requester data, packed.
- i_valid  in  N_REQ  per-requester data valid.
- o_ready  out  N_REQ  per-requester ready.
- o_busy  out  1  high while a job is owned.
- o_dma_start  out  1  start pulse to the DMA.
- o_dma_base_addr  out  32  to DMA i_base_addr.
- o_dma_byte_len  out  32  to DMA i_byte_len.
- i_dma_busy  in  1  from the DMA.
- i_dma_done  in  1  from the DMA.
- i_dma_error  in  1  from the DMA.
- o_dma_data  out  DATA_W  to DMA i_data.
- o_dma_valid  out  1  to DMA i_valid.
- i_dma_ready  in  1  from DMA o_ready.

Behaviour:
- Reset values: o_grant, o_done, o_error, o_busy, o_dma_start, o_dma_valid all 0; o_dma_base_addr, o_dma_byte_len, o_dma_data all 0; o_ready 0; RR pointer 0; FSM in IDLE.
- Reset asserted mid-job abandons the job immediately: no done or error is issued, and all outputs return to reset values next cycle.
- FSM states are IDLE, LAUNCH, RUN, RESP, GAP.
- IDLE:
  - When any i_req bit is set, pick the winner k: the first set bit searching from ptr+1 mod N_REQ upward, wrapping.
  - Next cycle: o_grant=onehot(k), o_busy=1, addr/len registered from slice k, and ptr<=k.
  - If len==0, go to RESP with no DMA launch. Otherwise go to LAUNCH.
- LAUNCH: o_dma_start=1 for exactly one cycle, then go to RUN. Addr and len stay stable from LAUNCH until RESP.
- RUN:
  - The stream mux is combinational from the o_grant register: o_dma_data=i_data[k], o_dma_valid=i_valid[k], o_ready[k]=i_dma_ready.
  - All non-owner o_ready bits are 0.
  - On i_dma_done, latch i_dma_error and go to RESP.
- RESP:
  - o_done[k]=1 and o_error[k]=latched error, for one cycle.
  - Next cycle: o_grant=0, o_busy=0, go to GAP.
  - A zero-length job reports error=0.
- GAP: one idle cycle, then IDLE. This guarantees o_dma_start stays low for at least 3 cycles between jobs, because the DMA edge-detects start.
- Latency:
  - Request seen in IDLE → o_grant set in 1 cycle → o_dma_start in 2 cycles.
  - i_dma_done → o_done in 1 cycle.
  - Minimum spacing between back-to-back jobs is 6 cycles plus the DMA time.
- Request sampling:
  - i_req is sampled only in IDLE.
  - Dropping i_req mid-job does not abort the job.
  - A request asserted by the owner again after its done competes normally, so with other requesters pending it gets the lowest RR priority.
- Simultaneous requests: exactly one winner; the others wait with their requests held.
- i_dma_done outside RUN is ignored.
- i_dma_busy is status only; the FSM does not depend on it.

Optional Feature:
- Macro name: DMA_WR_SCHED_TIMEOUT_EN.
- Defined:
  - A 32-bit counter clears on LAUNCH and increments in RUN.
  - On reaching TIMEOUT_CYCLES without i_dma_done, go to RESP with o_done[k]=o_error[k]=1.
  - Counter and latched error reset to 0.
- Undefined: no counter; RUN waits indefinitely for i_dma_done.

Decomposition:
- Package sa_dma_pkg holds:
  - enum wr_sched_state_t {IDLE, LAUNCH, RUN, RESP, GAP};
  - localparam ADDR_W=32 and LEN_W=32.
  - The function next_rr(req, ptr) returning a one-hot winner.
- One sub-module, dma_rr_pick: combinational round-robin picker with inputs req[N_REQ] and ptr, outputs onehot and index. It is reusable for a future read-side scheduler.

Test Plan:
- Single job: i_req=0001, addr=0x1000, len=64.
  - Expect o_grant=0001 one cycle after the request, then exactly one o_dma_start pulse.
  - When the DMA model raises i_dma_done, expect o_done=0001 with o_error=0000 one cycle later, then o_busy=0 the following cycle.
- Fairness: i_req=1111 held continuously.
  - Expect grant order 0010, 0100, 1000, 0001, 0010, with exactly one o_done per grant.
- Zero length: i_req=0100, len=0.
  - Expect o_grant=0100 then o_done=0100 with no o_dma_start, and o_error=0.
- Mux isolation: owner 1, with i_valid=1111 on distinct data values.
  - o_dma_data must equal i_data[1]; o_ready must be 0010 while i_dma_ready=1; no other requester's ready ever asserts.
- Reset mid-RUN: assert ARESET 3 cycles after o_dma_start.
  - Next cycle all outputs are 0 and no o_done is issued.
  - A subsequent i_req=0001 is served normally.
- Timeout (with DMA_WR_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=20): the DMA model never asserts done.
  - o_done and o_error assert for the owner 21 cycles after o_dma_start.
